irq_scheduler: RTL and testbench



---
 rtl/irq_scheduler_pkg.sv | 17 +
 rtl/irq_source.sv | 49 ++++
 rtl/irq_scheduler.sv | 104 ++++++++++
 tb/tb_irq_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_scheduler_pkg.sv
// Shared constants for the video interrupt scheduler: RST opcodes, FSM states and grant encoding.
package irq_scheduler_pkg;

    localparam logic [7:0] RST1 = 8'hCF;
    localparam logic [7:0] RST2 = 8'hD7;
    localparam logic [7:0] RST7 = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam int SRC_MID = 0;
    localparam int SRC_VBL = 1;
    localparam int NUM_SRC = 2;

endpackage

// File: rtl/irq_source.sv
// One interrupt source: rising-edge detect, sticky pending flag and saturating overrun counter.
module irq_source #(
    parameter int OVR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 level,
    input  logic                 clear,
    output logic                 pending,
    output logic [OVR_WIDTH-1:0] overrun
);

    logic                 prev_reg;
    logic                 pend_reg, pend_next;
    logic [OVR_WIDTH-1:0] ovr_reg, ovr_next;
    logic                 rise;

    assign rise = level & ~prev_reg;

    always_comb begin
        pend_next = pend_reg;
        ovr_next  = ovr_reg;
        // A new edge beats a same-cycle clear: it is a fresh event, not an overrun.
        if (rise) begin
            pend_next = 1'b1;
        end else if (clear) begin
            pend_next = 1'b0;
        end
        if (rise && pend_reg && !clear && (ovr_reg != {OVR_WIDTH{1'b1}})) begin
            ovr_next = ovr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= 1'b1;
            pend_reg <= 1'b0;
            ovr_reg  <= '0;
        end else begin
            prev_reg <= level;
            pend_reg <= pend_next;
            ovr_reg  <= ovr_next;
        end
    end

    assign pending = pend_reg;
    assign overrun = ovr_reg;

endmodule

// File: rtl/irq_scheduler.sv
// Arbitrates mid_screen and vblank onto the i8080 iint line and serves the INTA cycle with an RST opcode.
module irq_scheduler
    import irq_scheduler_pkg::*;
#(
    parameter logic [7:0] VEC_MID   = RST1,
    parameter logic [7:0] VEC_VBL   = RST2,
    parameter logic [7:0] VEC_SPUR  = RST7,
    parameter bit         VBL_FIRST = 1'b1,
    parameter int         OVR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mid_screen,
    input  logic                 vblank,
    input  logic                 inta,
    input  logic                 dbin,
    output logic                 iint,
    output logic [7:0]           vec_data,
    output logic                 vec_oe,
    output logic [OVR_WIDTH-1:0] ovr_mid,
    output logic [OVR_WIDTH-1:0] ovr_vbl
);

    logic [NUM_SRC-1:0] level_vec;
    logic [NUM_SRC-1:0] clear_vec;
    logic [NUM_SRC-1:0] pend_vec;
    logic [OVR_WIDTH-1:0] ovr_vec [NUM_SRC];

    state_t     state_reg, state_next;
    logic [7:0] vec_data_reg, vec_data_next;
    logic       ack_start;
    logic       grant_mid, grant_vbl;
    logic [7:0] sel_vec;

    assign level_vec[SRC_MID] = mid_screen;
    assign level_vec[SRC_VBL] = vblank;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_source #(
                .OVR_WIDTH (OVR_WIDTH)
            ) u_src (
                .clk     (clk),
                .rst_n   (rst_n),
                .level   (level_vec[gi]),
                .clear   (clear_vec[gi]),
                .pending (pend_vec[gi]),
                .overrun (ovr_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        grant_vbl = pend_vec[SRC_VBL] & (VBL_FIRST | ~pend_vec[SRC_MID]);
        grant_mid = pend_vec[SRC_MID] & ~grant_vbl;
        if (grant_vbl) begin
            sel_vec = VEC_VBL;
        end else if (grant_mid) begin
            sel_vec = VEC_MID;
        end else begin
            sel_vec = VEC_SPUR;
        end

        ack_start = (state_reg == IDLE) & inta & dbin;
        clear_vec = '0;
        clear_vec[SRC_MID] = ack_start & grant_mid;
        clear_vec[SRC_VBL] = ack_start & grant_vbl;

        state_next    = state_reg;
        vec_data_next = vec_data_reg;
        case (state_reg)
            IDLE: begin
                if (ack_start) begin
                    state_next    = ACK;
                    vec_data_next = sel_vec;
                end
            end
            ACK: begin
                if (!dbin) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            vec_data_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            vec_data_reg <= vec_data_next;
        end
    end

    // The opcode is driven from the first dbin cycle, before the latched copy exists.
    assign vec_data = ack_start ? sel_vec : vec_data_reg;
    assign vec_oe   = ack_start | ((state_reg == ACK) & dbin);
    assign iint     = (|pend_vec) & (state_reg == IDLE);
    assign ovr_mid  = ovr_vec[SRC_MID];
    assign ovr_vbl  = ovr_vec[SRC_VBL];

endmodule

// File: tb/tb_irq_scheduler.sv
// Randomized and directed bench for irq_scheduler with a reference model and an opcode scoreboard.
module tb_irq_scheduler;

    logic       clk;
    logic       rst_n;
    logic       mid_screen;
    logic       vblank;
    logic       inta;
    logic       dbin;
    logic       iint;
    logic [7:0] vec_data;
    logic       vec_oe;
    logic [3:0] ovr_mid;
    logic [3:0] ovr_vbl;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    bit m_pend_mid, m_pend_vbl, m_prev_mid, m_prev_vbl, m_in_ack;
    int m_ovr_mid, m_ovr_vbl;

    logic [7:0] exp_q[$];

    irq_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mid_screen (mid_screen),
        .vblank     (vblank),
        .inta       (inta),
        .dbin       (dbin),
        .iint       (iint),
        .vec_data   (vec_data),
        .vec_oe     (vec_oe),
        .ovr_mid    (ovr_mid),
        .ovr_vbl    (ovr_vbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend_mid = 0; m_pend_vbl = 0;
        m_prev_mid = 1; m_prev_vbl = 1;
        m_in_ack   = 0;
        m_ovr_mid  = 0; m_ovr_vbl = 0;
    endtask

    // One clock: drive inputs, check outputs at the negedge, advance the model at the posedge.
    task automatic step(input bit r, input bit m, input bit v, input bit a, input bit d);
        bit e_iint, e_oe, rise_m, rise_v, gnt_m, gnt_v, start;
        rst_n = r; mid_screen = m; vblank = v; inta = a; dbin = d;
        start  = !m_in_ack && a && d;
        e_iint = (m_pend_mid || m_pend_vbl) && !m_in_ack;
        e_oe   = m_in_ack ? d : start;
        gnt_v  = start && m_pend_vbl;
        gnt_m  = start && m_pend_mid && !m_pend_vbl;
        if (start) exp_q.push_back(gnt_v ? 8'hD7 : (gnt_m ? 8'hCF : 8'hFF));
        @(negedge clk);
        chk("iint", int'(iint), int'(e_iint));
        chk("vec_oe", int'(vec_oe), int'(e_oe));
        chk("ovr_mid", int'(ovr_mid), m_ovr_mid);
        chk("ovr_vbl", int'(ovr_vbl), m_ovr_vbl);
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            rise_m = m && !m_prev_mid;
            rise_v = v && !m_prev_vbl;
            if (rise_m && m_pend_mid && !gnt_m) m_ovr_mid = (m_ovr_mid < 15) ? m_ovr_mid + 1 : 15;
            if (rise_v && m_pend_vbl && !gnt_v) m_ovr_vbl = (m_ovr_vbl < 15) ? m_ovr_vbl + 1 : 15;
            m_pend_mid = rise_m || (m_pend_mid && !gnt_m);
            m_pend_vbl = rise_v || (m_pend_vbl && !gnt_v);
            m_in_ack   = m_in_ack ? d : start;
            m_prev_mid = m;
            m_prev_vbl = v;
        end
        #1;
    endtask

    // Scoreboard monitor: each vec_oe window consumes one expected opcode.
    initial begin : monitor
        bit active;
        logic [7:0] cur;
        active = 0;
        cur = 8'h00;
        forever begin
            @(negedge clk);
            if (vec_oe === 1'b1) begin
                if (!active) begin
                    active = 1;
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_vec_oe at %0t: got vec_data %0h expected no INTA service", $time, vec_data);
                        cur = 8'hxx;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (cur !== 8'hxx) chk("vec_data", int'(vec_data), int'(cur));
            end else begin
                active = 0;
            end
        end
    end

    initial begin
        rst_n = 0; mid_screen = 0; vblank = 1; inta = 0; dbin = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();

        // reset release with vblank already high: no edge
        repeat (2) step(0, 0, 1, 0, 0);
        repeat (20) step(1, 0, 1, 0, 0);
        chk("ovr_vbl_after_reset", int'(ovr_vbl), 0);

        // mid_screen edge, two-cycle dbin INTA
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("iint_after_mid_rise", int'(iint), 1);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("iint_after_mid_served", int'(iint), 0);

        // simultaneous rise: vblank served first
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 0, 0);
        chk("iint_still_pending_mid", int'(iint), 1);
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("iint_both_served", int'(iint), 0);

        // vblank overrun then saturation
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        chk("ovr_vbl_three_edges", int'(ovr_vbl), 2);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        chk("ovr_vbl_saturated", int'(ovr_vbl), 15);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);

        // spurious INTA
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);
        chk("iint_after_spurious", int'(iint), 0);

        // reset clears counters; then vblank rises on its own grant edge
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1);
        step(1, 0, 1, 0, 0);
        chk("iint_regrant_vbl", int'(iint), 1);
        chk("ovr_vbl_regrant", int'(ovr_vbl), 0);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);

        // reset during ACK
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        step(1, 1, 0, 0, 0);
        chk("vec_oe_after_ack_reset", int'(vec_oe), 0);
        chk("iint_after_ack_reset", int'(iint), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, m, v, a, d;
            r = ($urandom_range(0, 299) != 0);
            m = ($urandom_range(0, 7) == 0) ? !mid_screen : mid_screen;
            v = ($urandom_range(0, 7) == 0) ? !vblank : vblank;
            a = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 1) == 0);
            step(r, m, v, a, d);
        end
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
